// File: rtl/axa_undo_pkg.sv
// ---------------------------------------------------------------------------
// axa_undo_pkg
// Shared constants and types for the AXA undo stack.
//   WORD_W    : width of one AXA word (one stack entry)
//   DEPTH_DEF : default number of stack entries
//   state_e   : controller state (RUN = normal operation, CLEAR = zeroing)
// ---------------------------------------------------------------------------
package axa_undo_pkg;

  localparam int WORD_W    = 16;
  localparam int DEPTH_DEF = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/undo_stack_mem.sv
// ---------------------------------------------------------------------------
// undo_stack_mem
// Storage array for the undo stack: one synchronous write port and two
// registered read ports (pop and peek). The array itself has no reset; the
// controller zeroes it by sweeping the write port. Read registers reset to 0
// so the stack outputs are clean straight out of reset.
//   clk_i, rst_ni           : clock, async active-low reset (read regs only)
//   we_i, waddr_i, wdata_i  : write port
//   pop_re_i, pop_addr_i    : pop read; pop_rdata_o holds until next pop_re_i
//   peek_addr_i             : peek read, sampled every cycle
//   pop_rdata_o, peek_rdata_o : registered read data
// ---------------------------------------------------------------------------
module undo_stack_mem #(
  parameter int DEPTH = 16,
  parameter int PTRW  = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [PTRW-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_re_i,
  input  logic [PTRW-1:0]  pop_addr_i,
  input  logic [PTRW-1:0]  peek_addr_i,
  output logic [WIDTH-1:0] pop_rdata_o,
  output logic [WIDTH-1:0] peek_rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] pop_rdata_q;
  logic [WIDTH-1:0] peek_rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Reads return the pre-write contents, which gives the replace
  // (push + pop in one cycle) its pop-old-then-overwrite behaviour.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pop_rdata_q  <= '0;
      peek_rdata_q <= '0;
    end else begin
      if (pop_re_i) pop_rdata_q <= mem_q[pop_addr_i];
      peek_rdata_q <= mem_q[peek_addr_i];
    end
  end

  assign pop_rdata_o  = pop_rdata_q;
  assign peek_rdata_o = peek_rdata_q;

endmodule

// File: rtl/undo_stack_ctrl.sv
// ---------------------------------------------------------------------------
// undo_stack_ctrl
// Controller/arbiter for the AXA undo stack. Serialises pushes (old
// destination values from the ALU stage) and pops (undo/land logic) with a
// valid/ready handshake, owns the circular storage, pointer, count and error
// flags, and offers a registered peek port for SRC_UNDO operands.
//   clk_i, rst_ni                    : clock, async active-low reset
//   push_valid_i/push_data_i/push_ready_o : push handshake
//   pop_valid_i/pop_ready_o          : pop handshake
//   pop_data_o, pop_data_valid_o     : popped value (held) and 1-cycle strobe
//   peek_idx_i, peek_data_o, peek_valid_o : entry N from the top, registered
//   flush_i                          : clear the stack
//   count_o, full_o, empty_o         : occupancy
//   overflow_err_o, underflow_err_o, dropped_o, err_clr_i : sticky errors
// ---------------------------------------------------------------------------
module undo_stack_ctrl
  import axa_undo_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int PTRW        = 4,
  parameter int WIDTH       = WORD_W,
  parameter int DROP_OLDEST = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_ready_o,
  input  logic             pop_valid_i,
  output logic             pop_ready_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_data_valid_o,
  input  logic [PTRW-1:0]  peek_idx_i,
  output logic [WIDTH-1:0] peek_data_o,
  output logic             peek_valid_o,
  input  logic             flush_i,
  output logic [PTRW:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_err_o,
  output logic             underflow_err_o,
  output logic             dropped_o,
  input  logic             err_clr_i
);

  localparam logic [PTRW:0]   DEPTH_C  = (PTRW+1)'(DEPTH);
  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(DEPTH - 1);
  localparam logic            DROP_EN  = (DROP_OLDEST != 0);

  state_e            state_q, state_d;
  logic [PTRW-1:0]   top_q, top_d;     // next free slot
  logic [PTRW-1:0]   ci_q, ci_d;       // clear sweep index
  logic [PTRW:0]     count_q, count_d;
  logic              ovf_q, unf_q, drp_q;
  logic              pop_dv_q, peek_valid_q;

  logic              run, full;
  logic              push_acc, pop_acc;
  logic              mem_we;
  logic [PTRW-1:0]   mem_waddr, top_m1;
  logic [WIDTH-1:0]  mem_wdata, pop_rdata, peek_rdata;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_CLEAR;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (!flush_i && ci_q == LAST_IDX) state_d = ST_RUN;
      ST_RUN:   if (flush_i) state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run          = (state_q == ST_RUN);
    full         = (count_q == DEPTH_C);
    push_ready_o = run && (!full || DROP_EN);
    pop_ready_o  = run && (count_q != '0);
    // A flush in the same cycle wins over any handshake.
    push_acc     = push_valid_i && push_ready_o && !flush_i;
    pop_acc      = pop_valid_i && pop_ready_o && !flush_i;
    top_m1       = top_q - 1'b1;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = ci_q;
      mem_wdata = '0;
    end else begin
      mem_we    = push_acc;
      // Replace overwrites the current top instead of the free slot.
      mem_waddr = pop_acc ? top_m1 : top_q;
      mem_wdata = push_data_i;
    end
  end

  // ---------------- pointer / count next state ----------------
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ci_d    = ci_q;
    if (!run) begin
      ci_d = flush_i ? '0 : ci_q + 1'b1;
    end else if (flush_i) begin
      top_d   = '0;
      count_d = '0;
      ci_d    = '0;
    end else if (push_acc && !pop_acc) begin
      // When full (drop mode) the slot at top is the oldest entry, so
      // advancing top overwrites it while count saturates.
      top_d = top_q + 1'b1;
      if (!full) count_d = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      top_d   = top_m1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      top_q        <= '0;
      ci_q         <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      drp_q        <= 1'b0;
      pop_dv_q     <= 1'b0;
      peek_valid_q <= 1'b0;
    end else begin
      top_q        <= top_d;
      ci_q         <= ci_d;
      count_q      <= count_d;
      // Set takes priority over err_clr.
      ovf_q        <= (run && push_valid_i && full && !DROP_EN) || (ovf_q && !err_clr_i);
      unf_q        <= (run && pop_valid_i && (count_q == '0)) || (unf_q && !err_clr_i);
      drp_q        <= (push_acc && !pop_acc && full) || (drp_q && !err_clr_i);
      pop_dv_q     <= pop_acc;
      peek_valid_q <= run && ({1'b0, peek_idx_i} < count_q);
    end
  end

  undo_stack_mem #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .we_i         (mem_we),
    .waddr_i      (mem_waddr),
    .wdata_i      (mem_wdata),
    .pop_re_i     (pop_acc),
    .pop_addr_i   (top_m1),
    .peek_addr_i  (top_m1 - peek_idx_i),
    .pop_rdata_o  (pop_rdata),
    .peek_rdata_o (peek_rdata)
  );

  assign pop_data_o       = pop_rdata;
  assign pop_data_valid_o = pop_dv_q;
  assign peek_data_o      = peek_valid_q ? peek_rdata : '0;
  assign peek_valid_o     = peek_valid_q;
  assign count_o          = count_q;
  assign full_o           = full;
  assign empty_o          = (count_q == '0);
  assign overflow_err_o   = ovf_q;
  assign underflow_err_o  = unf_q;
  assign dropped_o        = drp_q;

endmodule
